// File: rtl/mem_arbiter.sv
// Single-port pmem arbiter shared by the I-side and D-side caches.
// D-side has fixed priority; a saturating starvation counter forces an I grant.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned LINE_W       = 128,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;

  logic d_req;
  logic i_forced;

  assign d_req    = d_read | d_write;
  assign i_forced = i_read && (starve_q == LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_resp_q  <= i_resp_d;
      d_resp_q  <= d_resp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_resp_d  = 1'b0;
    d_resp_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req && !i_forced) begin
          // Simultaneous read+write is served as a write.
          state_d = BUSY_D;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          wr_d    = d_write;
          rd_d    = !d_write;
          if (i_read) starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
          else        starve_d = '0;
        end else if (i_read) begin
          state_d  = BUSY_I;
          addr_d   = i_addr;
          wdata_d  = '0;
          rd_d     = 1'b1;
          wr_d     = 1'b0;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      BUSY_I: begin
        if (pmem_resp) begin
          i_rdata_d = pmem_rdata;
          i_resp_d  = 1'b1;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          state_d   = DONE;
        end
      end
      BUSY_D: begin
        if (pmem_resp) begin
          if (rd_q) d_rdata_d = pmem_rdata;
          d_resp_d = 1'b1;
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign i_resp       = i_resp_q;
  assign d_resp       = d_resp_q;

  d_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(d_read && d_write))
    else $warning("protocol error: d_read and d_write asserted together");

endmodule
